// File: rtl/riscv_def.sv
// Shared RV32IM definitions: default datapath width, aluop and funct3
// codes, and the execute-unit state encoding.
package riscv_def;

   localparam int DEFAULT_XLEN = 32;

   localparam logic [1:0] ALUOP_ADDR   = 2'b00;
   localparam logic [1:0] ALUOP_BRANCH = 2'b01;
   localparam logic [1:0] ALUOP_R      = 2'b10;
   localparam logic [1:0] ALUOP_I      = 2'b11;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide engine. Works on operand magnitudes, one bit
// per cycle, and applies the sign afterwards. Divide-by-zero and signed
// overflow are answered immediately on start (done in the same cycle).
module muldiv_iter
   import riscv_def::*;
#(
   parameter int XLEN = DEFAULT_XLEN,
   parameter int SHW  = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            abort,
   input  logic            start,
   input  logic            is_div,
   input  logic            signed_a,
   input  logic            signed_b,
   input  logic            want_hi,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam logic [SHW:0] ITERS = (SHW + 1)'(XLEN);
   localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

   logic              neg_a, neg_b;
   logic [XLEN-1:0]   mag_a, mag_b;
   logic              bypass_hit;
   logic [XLEN-1:0]   bypass_val;
   logic              busy, div_q, hi_q, neg_q;
   logic [SHW:0]      count;
   logic [2*XLEN-1:0] acc;
   logic [XLEN-1:0]   opnd;
   logic [XLEN:0]     add_sum, shifted, diff;
   logic [2*XLEN-1:0] mul_full;
   logic [XLEN-1:0]   div_half, iter_res;

   // Operand magnitudes, bypass detection and per-step datapath
   always_comb begin
      neg_a      = signed_a & op_a[XLEN-1];
      neg_b      = signed_b & op_b[XLEN-1];
      mag_a      = neg_a ? -op_a : op_a;
      mag_b      = neg_b ? -op_b : op_b;
      bypass_hit = 1'b0;
      bypass_val = '0;
      if (is_div && op_b == '0) begin
         bypass_hit = 1'b1;
         bypass_val = want_hi ? op_a : '1;
      end else if (is_div && signed_a && op_a == MIN_INT && op_b == '1) begin
         bypass_hit = 1'b1;
         bypass_val = want_hi ? '0 : op_a;
      end
      add_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? opnd : '0)};
      shifted  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
      diff     = shifted - {1'b0, opnd};
      mul_full = neg_q ? -acc : acc;
      div_half = hi_q ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
      if (div_q)
         iter_res = neg_q ? -div_half : div_half;
      else
         iter_res = hi_q ? mul_full[2*XLEN-1:XLEN] : mul_full[XLEN-1:0];
      done   = start ? bypass_hit : (busy && count == ITERS);
      result = start ? bypass_val : iter_res;
   end

   // Load on start, then one shift-add or restoring-subtract step per cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy  <= 1'b0;
         count <= '0;
         acc   <= '0;
         opnd  <= '0;
         div_q <= 1'b0;
         hi_q  <= 1'b0;
         neg_q <= 1'b0;
      end else if (start) begin
         busy  <= ~bypass_hit;
         count <= '0;
         acc   <= {{XLEN{1'b0}}, mag_a};
         opnd  <= mag_b;
         div_q <= is_div;
         hi_q  <= want_hi;
         neg_q <= (is_div && want_hi) ? neg_a : (neg_a ^ neg_b);
      end else if (abort) begin
         busy <= 1'b0;
      end else if (busy) begin
         if (count == ITERS) begin
            busy <= 1'b0;
         end else begin
            count <= count + 1'b1;
            if (div_q) begin
               if (!diff[XLEN])
                  acc <= {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
               else
                  acc <= {shifted[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            end else begin
               acc <= {add_sum, acc[XLEN-1:1]};
            end
         end
      end
   end

endmodule

// File: rtl/alu_muldiv.sv
// Handshaked EX-stage execute unit: base RV32I ALU plus the M extension,
// with every result registered behind a valid/ready pair.
module alu_muldiv
   import riscv_def::*;
#(
   parameter int XLEN = DEFAULT_XLEN,
   parameter int SHW  = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] read_data1,
   input  logic [XLEN-1:0] read_data2,
   input  logic [XLEN-1:0] immediate,
   input  logic            alusrc,
   input  logic            inst30,
   input  logic            inst25,
   input  logic [2:0]      funct3,
   input  logic [1:0]      aluop,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] alu_result,
   output logic            alu_branch
);

   state_t            state;
   logic [XLEN-1:0]   op1, op2;
   logic [SHW-1:0]    shamt;
   logic [XLEN-1:0]   base_result;
   logic              base_branch;
   logic              accept, is_m, is_div;
   logic              md_signed_a, md_signed_b, md_want_hi;
   logic              md_done;
   logic [XLEN-1:0]   md_result;

   assign in_ready = ~flush & ((state == ST_IDLE) | ((state == ST_DONE) & out_ready));
   assign accept   = in_valid & in_ready;
   assign op1      = read_data1;
   assign op2      = alusrc ? immediate : read_data2;
   assign shamt    = op2[SHW-1:0];
   assign is_m     = (aluop == ALUOP_R) & inst25;
   assign is_div   = funct3[2];

   // Signedness and half-select for the multiply/divide engine
   always_comb begin
      if (is_div) begin
         md_signed_a = (funct3 == F3_DIV) || (funct3 == F3_REM);
         md_signed_b = md_signed_a;
         md_want_hi  = (funct3 == F3_REM) || (funct3 == F3_REMU);
      end else begin
         md_signed_a = (funct3 != F3_MULHU);
         md_signed_b = (funct3 == F3_MUL) || (funct3 == F3_MULH);
         md_want_hi  = (funct3 != F3_MUL);
      end
   end

   // Single-cycle base ALU and branch comparator
   always_comb begin
      base_result = '0;
      base_branch = 1'b0;
      case (aluop)
         ALUOP_ADDR: base_result = op1 + op2;
         ALUOP_BRANCH: begin
            case (funct3)
               F3_BEQ:  base_branch = (op1 == op2);
               F3_BNE:  base_branch = (op1 != op2);
               F3_BLT:  base_branch = ($signed(op1) < $signed(op2));
               F3_BGE:  base_branch = ($signed(op1) >= $signed(op2));
               F3_BLTU: base_branch = (op1 < op2);
               F3_BGEU: base_branch = (op1 >= op2);
               default: base_branch = 1'b0;
            endcase
         end
         default: begin
            case (funct3)
               F3_ADD:  base_result = ((aluop == ALUOP_R) && inst30) ? op1 - op2 : op1 + op2;
               F3_SLL:  base_result = op1 << shamt;
               F3_SLT:  base_result = XLEN'($signed(op1) < $signed(op2));
               F3_SLTU: base_result = XLEN'(op1 < op2);
               F3_XOR:  base_result = op1 ^ op2;
               F3_SR:   base_result = inst30 ? XLEN'($signed(op1) >>> shamt) : op1 >> shamt;
               F3_OR:   base_result = op1 | op2;
               F3_AND:  base_result = op1 & op2;
               default: base_result = '0;
            endcase
         end
      endcase
   end

   muldiv_iter #(.XLEN(XLEN), .SHW(SHW)) u_muldiv (
      .clk      (clk),
      .rst      (rst),
      .abort    (flush),
      .start    (accept & is_m),
      .is_div   (is_div),
      .signed_a (md_signed_a),
      .signed_b (md_signed_b),
      .want_hi  (md_want_hi),
      .op_a     (op1),
      .op_b     (op2),
      .done     (md_done),
      .result   (md_result)
   );

   // Control FSM and registered result/branch outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         out_valid  <= 1'b0;
         alu_result <= '0;
         alu_branch <= 1'b0;
      end else if (flush) begin
         if (state != ST_IDLE) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
         end
      end else if (accept) begin
         if (is_m && !md_done) begin
            state     <= ST_CALC;
            out_valid <= 1'b0;
         end else begin
            state      <= ST_DONE;
            out_valid  <= 1'b1;
            alu_result <= is_m ? md_result : base_result;
            alu_branch <= is_m ? 1'b0 : base_branch;
         end
      end else begin
         case (state)
            ST_CALC: begin
               if (md_done) begin
                  state      <= ST_DONE;
                  out_valid  <= 1'b1;
                  alu_result <= md_result;
                  alu_branch <= 1'b0;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state     <= ST_IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed self-checking bench for alu_muldiv with hand-computed results.
module tb_alu_muldiv;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] read_data1 = '0;
   logic [31:0] read_data2 = '0;
   logic [31:0] immediate = '0;
   logic        alusrc = 1'b0;
   logic        inst30 = 1'b0;
   logic        inst25 = 1'b0;
   logic [2:0]  funct3 = '0;
   logic [1:0]  aluop = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] alu_result;
   logic        alu_branch;

   int nChecks = 0;
   int nFails  = 0;
   logic readyLeak;
   logic seenValid;
   int cycles;

   alu_muldiv dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .read_data1 (read_data1),
      .read_data2 (read_data2),
      .immediate  (immediate),
      .alusrc     (alusrc),
      .inst30     (inst30),
      .inst25     (inst25),
      .funct3     (funct3),
      .aluop      (aluop),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .alu_result (alu_result),
      .alu_branch (alu_branch)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   // Count one comparison and report it if it does not match
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      nChecks++;
      if (observed !== expected) begin
         nFails++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Present a request with in_valid raised
   task automatic applyStimulus(input logic [1:0] op, input logic [2:0] f3, input logic i30, input logic i25,
                                input logic src, input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm);
      aluop      = op;
      funct3     = f3;
      inst30     = i30;
      inst25     = i25;
      alusrc     = src;
      read_data1 = rs1;
      read_data2 = rs2;
      immediate  = imm;
      in_valid   = 1'b1;
   endtask

   // Advance to just after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Single-cycle request: result must be visible right after the accept edge
   task automatic runQuick(input string tag, input logic [1:0] op, input logic [2:0] f3, input logic i30,
                           input logic i25, input logic src, input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic [31:0] imm, input logic [31:0] expRes, input logic expBr);
      applyStimulus(op, f3, i30, i25, src, rs1, rs2, imm);
      step();
      in_valid = 1'b0;
      checkOutput({tag, " valid"}, 32'(out_valid), 32'd1);
      checkOutput({tag, " result"}, alu_result, expRes);
      checkOutput({tag, " branch"}, 32'(alu_branch), 32'(expBr));
   endtask

   // Iterative M op: check latency, in_ready low while busy, and the result
   task automatic runIter(input string tag, input logic [2:0] f3, input logic [31:0] rs1,
                          input logic [31:0] rs2, input logic [31:0] expRes);
      applyStimulus(2'b10, f3, 1'b0, 1'b1, 1'b0, rs1, rs2, 32'd0);
      step();
      in_valid = 1'b0;
      checkOutput({tag, " not yet valid"}, 32'(out_valid), 32'd0);
      readyLeak = 1'b0;
      cycles = 0;
      do begin
         step();
         cycles++;
         if (!out_valid && in_ready) readyLeak = 1'b1;
      end while (!out_valid && cycles < 100);
      checkOutput({tag, " valid"}, 32'(out_valid), 32'd1);
      checkOutput({tag, " latency"}, 32'(cycles), 32'd33);
      checkOutput({tag, " in_ready in calc"}, 32'(readyLeak), 32'd0);
      checkOutput({tag, " result"}, alu_result, expRes);
   endtask

   initial begin
      // Reset state
      #2 rst = 1'b0;
      #1;
      checkOutput("reset out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset result", alu_result, 32'd0);
      checkOutput("reset branch", 32'(alu_branch), 32'd0);
      checkOutput("reset in_ready", 32'(in_ready), 32'd1);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      step();

      // ADD then SUB back to back
      applyStimulus(2'b10, 3'b000, 1'b0, 1'b0, 1'b0, 32'd5, 32'd7, 32'd0);
      checkOutput("add in_ready", 32'(in_ready), 32'd1);
      step();
      checkOutput("add valid", 32'(out_valid), 32'd1);
      checkOutput("add result", alu_result, 32'd12);
      checkOutput("sub in_ready", 32'(in_ready), 32'd1);
      applyStimulus(2'b10, 3'b000, 1'b1, 1'b0, 1'b0, 32'd5, 32'd7, 32'd0);
      step();
      in_valid = 1'b0;
      checkOutput("sub valid", 32'(out_valid), 32'd1);
      checkOutput("sub result", alu_result, 32'hFFFF_FFFE);
      step();
      checkOutput("drain valid", 32'(out_valid), 32'd0);

      // Base ops and branches
      runQuick("blt", 2'b01, 3'b100, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b1);
      runQuick("bltu", 2'b01, 3'b110, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b0);
      runQuick("beq", 2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 32'd9, 32'd9, 32'd0, 32'd0, 1'b1);
      runQuick("bgeu", 2'b01, 3'b111, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b1);
      runQuick("undef br", 2'b01, 3'b010, 1'b0, 1'b0, 1'b0, 32'd1, 32'd1, 32'd0, 32'd0, 1'b0);
      runQuick("srai", 2'b11, 3'b101, 1'b1, 1'b0, 1'b1, 32'h8000_0000, 32'd0, 32'd4, 32'hF800_0000, 1'b0);
      runQuick("srl", 2'b10, 3'b101, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'd4, 32'd0, 32'h0800_0000, 1'b0);
      runQuick("sltu", 2'b10, 3'b011, 1'b0, 1'b0, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b0);
      runQuick("slt", 2'b10, 3'b010, 1'b0, 1'b0, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0);
      runQuick("addr", 2'b00, 3'b010, 1'b0, 1'b0, 1'b1, 32'h0000_1000, 32'd0, 32'hFFFF_FFFC, 32'h0000_0FFC, 1'b0);

      // Iterative multiply and divide
      runIter("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
      runIter("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      runIter("mul", 3'b000, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD);
      runIter("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      runIter("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
      runIter("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
      runIter("divu", 3'b101, 32'd100, 32'd7, 32'd14);
      runIter("remu", 3'b111, 32'd100, 32'd7, 32'd2);

      // Bypass cases complete in one cycle
      runQuick("divu by 0", 2'b10, 3'b101, 1'b0, 1'b1, 1'b0, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0);
      runQuick("remu by 0", 2'b10, 3'b111, 1'b0, 1'b1, 1'b0, 32'd7, 32'd0, 32'd0, 32'd7, 1'b0);
      runQuick("rem ovf", 2'b10, 3'b110, 1'b0, 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0);
      runQuick("div ovf", 2'b10, 3'b100, 1'b0, 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
      step();

      // Backpressure: result held while out_ready is low
      out_ready = 1'b0;
      runQuick("hold addi", 2'b11, 3'b000, 1'b0, 1'b0, 1'b1, 32'd100, 32'd0, 32'd23, 32'd123, 1'b0);
      applyStimulus(2'b10, 3'b000, 1'b1, 1'b0, 1'b0, 32'd50, 32'd8, 32'd0);
      checkOutput("hold in_ready", 32'(in_ready), 32'd0);
      for (int i = 0; i < 5; i++) begin
         step();
         checkOutput("hold result", alu_result, 32'd123);
         checkOutput("hold valid", 32'(out_valid), 32'd1);
      end
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      checkOutput("release valid", 32'(out_valid), 32'd1);
      checkOutput("release result", alu_result, 32'd42);
      step();
      checkOutput("release drain", 32'(out_valid), 32'd0);

      // Flush in the middle of a divide
      applyStimulus(2'b10, 3'b101, 1'b0, 1'b1, 1'b0, 32'd100, 32'd3, 32'd0);
      step();
      in_valid = 1'b0;
      repeat (10) step();
      flush = 1'b1;
      applyStimulus(2'b10, 3'b000, 1'b0, 1'b0, 1'b0, 32'd1, 32'd1, 32'd0);
      checkOutput("flush in_ready", 32'(in_ready), 32'd0);
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      checkOutput("flush valid", 32'(out_valid), 32'd0);
      seenValid = 1'b0;
      repeat (40) begin
         step();
         if (out_valid) seenValid = 1'b1;
      end
      checkOutput("flush no output", 32'(seenValid), 32'd0);
      runQuick("after flush add", 2'b10, 3'b000, 1'b0, 1'b0, 1'b0, 32'd2, 32'd3, 32'd0, 32'd5, 1'b0);

      // Reset in the middle of a multiply
      applyStimulus(2'b10, 3'b000, 1'b0, 1'b1, 1'b0, 32'd6, 32'd7, 32'd0);
      step();
      in_valid = 1'b0;
      repeat (10) step();
      rst = 1'b0;
      #1;
      checkOutput("mid reset valid", 32'(out_valid), 32'd0);
      checkOutput("mid reset result", alu_result, 32'd0);
      checkOutput("mid reset in_ready", 32'(in_ready), 32'd1);
      #2 rst = 1'b1;
      seenValid = 1'b0;
      repeat (40) begin
         step();
         if (out_valid) seenValid = 1'b1;
      end
      checkOutput("reset no output", 32'(seenValid), 32'd0);
      runQuick("after reset add", 2'b10, 3'b000, 1'b0, 1'b0, 1'b0, 32'd20, 32'd22, 32'd0, 32'd42, 1'b0);

      step();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
